// File: rtl/peio_pkg.sv
// Shared types and default sizes for the PE I/O host-side controller.
package peio_pkg;

   localparam int PEIO_DWIDTH = 32;
   localparam int PEIO_AWIDTH = 8;
   localparam int PEIO_DEPTH  = 256;

   // Matches the PE instruction pipeline: two instruction registers,
   // the memory read and the output register.
   localparam int PEIO_STORE_LAT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFETCH,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } peio_state_t;

endpackage

// File: rtl/io_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module io_buf_ram
   import peio_pkg::*;
#(
   parameter int DWIDTH = PEIO_DWIDTH,
   parameter int AWIDTH = PEIO_AWIDTH,
   parameter int DEPTH  = PEIO_DEPTH
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [DWIDTH-1:0] rd_data
);

   logic [DWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read data holds between reads so the host sees a stable value.
   always_ff @(posedge Clk) begin
      if (Reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/peio_io_ctrl.sv
// Host-side PE I/O controller: streams IBuf onto PE_Load and captures PE_Store into OBuf.
// Optional run-cycle counter enabled by defining PEIO_IO_CTRL_PERF_EN.
module peio_io_ctrl
   import peio_pkg::*;
#(
   parameter int DWIDTH    = PEIO_DWIDTH,
   parameter int AWIDTH    = PEIO_AWIDTH,
   parameter int DEPTH     = PEIO_DEPTH,
   parameter int STORE_LAT = PEIO_STORE_LAT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Host_Wr_En,
   input  logic              Host_Rd_En,
   input  logic [AWIDTH-1:0] Host_Addr,
   input  logic [DWIDTH-1:0] Host_Wr_Data,
   output logic [DWIDTH-1:0] Host_Rd_Data,
   output logic              Host_Err,
   input  logic              Start,
   input  logic [AWIDTH:0]   Cycle_Count,
   output logic              Busy,
   output logic              Done,
   output logic [DWIDTH-1:0] PE_Load,
   input  logic [DWIDTH-1:0] PE_Store,
`ifdef PEIO_IO_CTRL_PERF_EN
   output logic [31:0]       Run_Cycles,
`endif
   output logic              PE_Array_Busy
);

   // j spans RUN plus DRAIN, so it needs room beyond the buffer size.
   localparam int              JW      = AWIDTH + 2;
   localparam logic [AWIDTH:0] DEPTH_N = (AWIDTH + 1)'(DEPTH);
   localparam logic [JW-1:0]   LAT_J   = JW'(STORE_LAT);

   if (DEPTH > (2 ** AWIDTH)) begin : g_depth_chk
      $error("peio_io_ctrl: DEPTH exceeds the address range");
   end

   peio_state_t       state, state_nxt;
   logic [AWIDTH:0]   n_r;
   logic [JW-1:0]     j_r;
   logic [AWIDTH:0]   n_start;
   logic              idle_like;
   logic              start_ok;
   logic              host_ok;
   logic              last_run;
   logic              last_drain;

   logic              ibuf_wr_en;
   logic              ibuf_rd_en;
   logic [AWIDTH-1:0] ibuf_rd_addr;
   logic [DWIDTH-1:0] ibuf_rd_p1;
   logic              obuf_wr_en;
   logic [AWIDTH-1:0] obuf_wr_addr;
   logic              obuf_rd_en;

   assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
   assign start_ok   = Start && idle_like;
   assign n_start    = (Cycle_Count > DEPTH_N) ? DEPTH_N : Cycle_Count;
   assign host_ok    = idle_like && ({1'b0, Host_Addr} < DEPTH_N);
   assign last_run   = (j_r == (JW'(n_r) - JW'(1)));
   assign last_drain = (j_r == (JW'(n_r) + LAT_J - JW'(1)));

   // ---------------- controller FSM ----------------
   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      Busy          = 1'b0;
      Done          = 1'b0;
      PE_Array_Busy = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (Start) state_nxt = (n_start == '0) ? ST_DONE : ST_PREFETCH;
         end
         ST_PREFETCH: begin
            Busy      = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            Busy          = 1'b1;
            PE_Array_Busy = 1'b1;
            if (last_run) state_nxt = (STORE_LAT == 0) ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            Busy = 1'b1;
            if (last_drain) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            Done = 1'b1;
            if (Start) state_nxt = (n_start == '0) ? ST_DONE : ST_PREFETCH;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- run length, cycle index and host error ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         n_r      <= '0;
         j_r      <= '0;
         Host_Err <= 1'b0;
      end else begin
         Host_Err <= ((Host_Wr_En || Host_Rd_En) && !host_ok) || (Start && !idle_like);
         if (start_ok) n_r <= n_start;
         if ((state == ST_RUN) || (state == ST_DRAIN)) j_r <= j_r + JW'(1);
         else                                          j_r <= '0;
      end
   end

   // ---------------- IBuf: host writes, controller prefetches ----------------
   // The read issued in cycle k lands as PE_Load in cycle k+1; the final
   // RUN cycle has nothing left to fetch.
   assign ibuf_wr_en   = Host_Wr_En && host_ok;
   assign ibuf_rd_en   = (state == ST_PREFETCH) || ((state == ST_RUN) && !last_run);
   assign ibuf_rd_addr = (state == ST_PREFETCH) ? '0 : AWIDTH'(j_r + JW'(1));
   assign PE_Load      = (state == ST_RUN) ? ibuf_rd_p1 : '0;

   io_buf_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .DEPTH  (DEPTH)
   ) u_ibuf (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_en   (ibuf_wr_en),
      .wr_addr (Host_Addr),
      .wr_data (Host_Wr_Data),
      .rd_en   (ibuf_rd_en),
      .rd_addr (ibuf_rd_addr),
      .rd_data (ibuf_rd_p1)
   );

   // ---------------- OBuf: store capture, host reads ----------------
   // A store issued in cycle j arrives STORE_LAT cycles later.
   assign obuf_wr_en   = ((state == ST_RUN) || (state == ST_DRAIN)) && (j_r >= LAT_J);
   assign obuf_wr_addr = AWIDTH'(j_r - LAT_J);
   assign obuf_rd_en   = Host_Rd_En && host_ok;

   io_buf_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .DEPTH  (DEPTH)
   ) u_obuf (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_en   (obuf_wr_en),
      .wr_addr (obuf_wr_addr),
      .wr_data (PE_Store),
      .rd_en   (obuf_rd_en),
      .rd_addr (Host_Addr),
      .rd_data (Host_Rd_Data)
   );

`ifdef PEIO_IO_CTRL_PERF_EN
   logic [31:0] run_cycles_r;

   always_ff @(posedge Clk) begin
      if (Reset)         run_cycles_r <= '0;
      else if (start_ok) run_cycles_r <= '0;
      else if (Busy)     run_cycles_r <= run_cycles_r + 32'd1;
   end

   assign Run_Cycles = run_cycles_r;
`endif

endmodule
